// File: rtl/fe_mul_arb_pkg.sv
// Shared definitions for the field-multiplier arbiter: default element width,
// arbiter state encoding and the fe_mulx handshake convention.
package fe_mul_arb_pkg;

    localparam int FE_W_DEFAULT = 320;
    localparam int LIMB_W       = 32;
    localparam int NLIMB        = FE_W_DEFAULT / LIMB_W;

    // fe_mulx handshake: mul_valid is a single-cycle start pulse and mul_a/mul_b
    // stay stable until the matching single-cycle mul_done; there is no ready,
    // so a new start is only issued once the previous done has been taken.
    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_WAIT = 1'b1
    } arb_state_t;

    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fe_mul_arb_rr_pick.sv
// Round-robin picker: first set request bit scanning from ptr upwards, modulo N.
// Purely combinational so it can front any shared resource.
module rr_pick
    import fe_mul_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  win,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        int j;
        logic found;
        j     = 0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!found && req[j]) begin
                found = 1'b1;
                idx   = IW'(j);
            end
        end
        any = found;
        win = found ? (N'(1) << idx) : '0;
    end

endmodule

// File: rtl/fe_mul_arb.sv
// Shares one fe_mulx between NREQ requesters: round-robin grant, operand capture,
// start pulse to the multiplier and a per-requester done pulse with the product.
module fe_mul_arb
    import fe_mul_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int FE_W = FE_W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*FE_W-1:0] op_a_flat,
    input  logic [NREQ*FE_W-1:0] op_b_flat,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic [FE_W-1:0]      res,
    output logic                 busy,
    output logic [FE_W-1:0]      mul_a,
    output logic [FE_W-1:0]      mul_b,
    output logic                 mul_valid,
    input  logic [FE_W-1:0]      mul_res,
    input  logic                 mul_done,
    output logic                 state_dbg
);

    localparam int IW = idx_width(NREQ);

    arb_state_t      state, state_n;
    logic [IW-1:0]   ptr, owner;
    logic [IW-1:0]   pick_idx;
    logic [NREQ-1:0] pick_win;
    logic            pick_any;
    logic            grant_en, finish_en;

    rr_pick #(
        .N  (NREQ),
        .IW (IW)
    ) u_pick (
        .req (req),
        .ptr (ptr),
        .win (pick_win),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign state_dbg = logic'(state);

    // A mul_done coinciding with our own start pulse cannot belong to this
    // operation, so completion is only accepted once mul_valid has dropped.
    always_comb begin
        state_n   = state;
        grant_en  = 1'b0;
        finish_en = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (pick_any) begin
                    grant_en = 1'b1;
                    state_n  = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                if (mul_done && !mul_valid) begin
                    finish_en = 1'b1;
                    state_n   = ARB_IDLE;
                end
            end
            default: state_n = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ARB_IDLE;
            ptr       <= '0;
            owner     <= '0;
            gnt       <= '0;
            done      <= '0;
            res       <= '0;
            busy      <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
            mul_valid <= 1'b0;
        end else begin
            state     <= state_n;
            gnt       <= '0;
            done      <= '0;
            mul_valid <= 1'b0;
            if (grant_en) begin
                mul_a     <= op_a_flat[int'(pick_idx)*FE_W +: FE_W];
                mul_b     <= op_b_flat[int'(pick_idx)*FE_W +: FE_W];
                owner     <= pick_idx;
                gnt       <= pick_win;
                mul_valid <= 1'b1;
                busy      <= 1'b1;
                if (pick_idx == IW'(NREQ - 1)) begin
                    ptr <= '0;
                end else begin
                    ptr <= pick_idx + 1'b1;
                end
            end
            if (finish_en) begin
                res  <= mul_res;
                done <= NREQ'(1) << owner;
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fe_mul_arb.sv
// Directed bench for fe_mul_arb: stub multiplier, per-cycle reference model,
// grant-order scoreboard and hand-computed literal expectations.
module tb_fe_mul_arb;
    import fe_mul_arb_pkg::*;

    localparam int NREQ = 4;
    localparam int FE_W = 320;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NREQ-1:0]      req = '0;
    logic [NREQ*FE_W-1:0] op_a_flat = '0;
    logic [NREQ*FE_W-1:0] op_b_flat = '0;
    logic [NREQ-1:0]      gnt, done;
    logic [FE_W-1:0]      res, mul_a, mul_b, mul_res;
    logic                 busy, mul_valid, mul_done, state_dbg;

    fe_mul_arb #(.NREQ(NREQ), .FE_W(FE_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .op_a_flat (op_a_flat),
        .op_b_flat (op_b_flat),
        .gnt       (gnt),
        .done      (done),
        .res       (res),
        .busy      (busy),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_valid (mul_valid),
        .mul_res   (mul_res),
        .mul_done  (mul_done),
        .state_dbg (state_dbg)
    );

    // ---------------- multiplier stub ----------------
    // Product of limb 0 of each operand, upper limbs zero; done after lat cycles.
    logic            auto_done;
    logic            manual_done = 1'b0;
    logic [FE_W-1:0] stub_res;
    logic [FE_W-1:0] junk_res = {10{32'hdead_beef}};
    int              stub_cnt;
    int              lat = 3;

    assign mul_done = auto_done | manual_done;
    assign mul_res  = manual_done ? junk_res : stub_res;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            auto_done <= 1'b0;
            stub_cnt  <= 0;
            stub_res  <= '0;
        end else begin
            auto_done <= 1'b0;
            if (mul_valid) begin
                stub_res <= FE_W'(64'(mul_a[31:0]) * 64'(mul_b[31:0]));
                stub_cnt <= lat;
            end else if (stub_cnt > 0) begin
                stub_cnt <= stub_cnt - 1;
                if (stub_cnt == 1) auto_done <= 1'b1;
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic int pick_rr(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return 0;
    endfunction

    function automatic int onehot_idx(input logic [NREQ-1:0] v);
        for (int k = 0; k < NREQ; k++) begin
            if (v[k]) return k;
        end
        return -1;
    endfunction

    logic            m_busy = 1'b0;
    int              m_ptr = 0;
    int              m_owner = 0;
    int              model_pick;
    logic [NREQ-1:0] e_gnt = '0, e_done = '0;
    logic            e_mv = 1'b0;
    logic [FE_W-1:0] e_res = '0, e_a = '0, e_b = '0;

    assign model_pick = pick_rr(req, m_ptr);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy  <= 1'b0;
            m_ptr   <= 0;
            m_owner <= 0;
            e_gnt   <= '0;
            e_done  <= '0;
            e_mv    <= 1'b0;
            e_res   <= '0;
            e_a     <= '0;
            e_b     <= '0;
        end else begin
            e_gnt  <= '0;
            e_done <= '0;
            e_mv   <= 1'b0;
            if (!m_busy && req != '0) begin
                e_gnt   <= NREQ'(1) << model_pick;
                e_mv    <= 1'b1;
                m_busy  <= 1'b1;
                m_owner <= model_pick;
                m_ptr   <= (model_pick + 1) % NREQ;
                e_a     <= op_a_flat[model_pick*FE_W +: FE_W];
                e_b     <= op_b_flat[model_pick*FE_W +: FE_W];
            end else if (m_busy && mul_done && !e_mv) begin
                e_res  <= mul_res;
                e_done <= NREQ'(1) << m_owner;
                m_busy <= 1'b0;
            end
        end
    end

    // ---------------- scoreboard ----------------
    int              n_checks = 0;
    int              n_fail = 0;
    logic [1:0]      exp_q[$];

    task automatic chk(input string name, input logic [FE_W-1:0] act, input logic [FE_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("gnt", FE_W'(gnt), FE_W'(e_gnt));
        chk("done", FE_W'(done), FE_W'(e_done));
        chk("busy", FE_W'(busy), FE_W'(m_busy));
        chk("state_dbg", FE_W'(state_dbg), FE_W'(m_busy));
        chk("mul_valid", FE_W'(mul_valid), FE_W'(e_mv));
        chk("res", res, e_res);
        chk("mul_a", mul_a, e_a);
        chk("mul_b", mul_b, e_b);
        if (gnt != '0) begin
            if (exp_q.size() == 0) begin
                chk("gnt_unexpected", FE_W'(gnt), '0);
            end else begin
                chk("gnt_order", FE_W'(onehot_idx(gnt)), FE_W'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_ops(input int i, input logic [FE_W-1:0] a, input logic [FE_W-1:0] b);
        op_a_flat[i*FE_W +: FE_W] = a;
        op_b_flat[i*FE_W +: FE_W] = b;
    endtask

    task automatic wait_gnt(input int max, output logic [NREQ-1:0] g);
        g = '0;
        for (int c = 0; c < max; c++) begin
            @(negedge clk);
            if (gnt != '0) begin
                g = gnt;
                return;
            end
        end
        chk("wait_gnt_timeout", 1, 0);
    endtask

    task automatic wait_done(input int max, output logic [NREQ-1:0] d);
        d = '0;
        for (int c = 0; c < max; c++) begin
            @(negedge clk);
            if (done != '0) begin
                d   = done;
                req = req & ~done;
                return;
            end
        end
        chk("wait_done_timeout", 1, 0);
    endtask

    // Requesters drop their request in the cycle they see their done.
    task automatic drain(input int max);
        for (int c = 0; c < max; c++) begin
            @(negedge clk);
            if (done != '0) req = req & ~done;
            if (req == '0 && !busy) return;
        end
        chk("drain_timeout", 1, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        logic [NREQ-1:0] g, d;
        int              ndone;

        for (int i = 0; i < NREQ; i++) begin
            set_ops(i, {{9{32'h1111_0000 + 32'(i)}}, 32'(i + 2)},
                       {{9{32'h2222_0000 + 32'(i)}}, 32'(i + 5)});
        end

        // reset held with all requests pending
        #1 rst = 1'b0;
        req = 4'b1111;
        repeat (3) @(negedge clk);
        chk("rst_gnt", FE_W'(gnt), '0);
        chk("rst_busy", FE_W'(busy), '0);
        chk("rst_mul_valid", FE_W'(mul_valid), '0);
        chk("rst_mul_a", mul_a, '0);
        chk("rst_res", res, '0);
        rst = 1'b1;

        // contention: 0,1,2,3 then again from 0
        for (int i = 0; i < NREQ; i++) exp_q.push_back(2'(i));
        wait_gnt(20, g);
        chk("first_gnt", FE_W'(g), FE_W'(4'b0001));
        drain(200);
        req = 4'b1111;
        for (int i = 0; i < NREQ; i++) exp_q.push_back(2'(i));
        wait_gnt(20, g);
        chk("wrap_gnt", FE_W'(g), FE_W'(4'b0001));
        drain(200);

        // fairness: req[0] held, req[3] raised -> 0,3,0,3
        req = 4'b1001;
        exp_q.push_back(2'd0); exp_q.push_back(2'd3);
        exp_q.push_back(2'd0); exp_q.push_back(2'd3);
        ndone = 0;
        for (int c = 0; c < 200 && ndone < 4; c++) begin
            @(negedge clk);
            if (done != '0) begin
                ndone++;
                if (ndone == 4) req = '0;
            end
        end
        chk("fair_dones", FE_W'(ndone), FE_W'(4));
        @(negedge clk);

        // single request, operands changed after grant
        set_ops(2, FE_W'(2), FE_W'(3));
        req = 4'b0100;
        exp_q.push_back(2'd2);
        wait_gnt(20, g);
        chk("single_gnt", FE_W'(g), FE_W'(4'b0100));
        set_ops(2, {10{32'h5555_aaaa}}, {10{32'h0f0f_f0f0}});
        wait_done(50, d);
        chk("single_done", FE_W'(d), FE_W'(4'b0100));
        chk("single_res", res, FE_W'(6));
        chk("single_busy_at_done", FE_W'(busy), '0);

        // spurious mul_done in IDLE
        @(negedge clk);
        manual_done = 1'b1;
        @(negedge clk);
        manual_done = 1'b0;
        chk("spur_idle_done", FE_W'(done), '0);
        chk("spur_idle_res", res, FE_W'(6));

        // mul_done coinciding with mul_valid must be ignored
        set_ops(1, FE_W'(7), FE_W'(5));
        req = 4'b0010;
        exp_q.push_back(2'd1);
        wait_gnt(20, g);
        chk("valid_cyc_gnt", FE_W'(g), FE_W'(4'b0010));
        manual_done = 1'b1;
        @(negedge clk);
        manual_done = 1'b0;
        chk("valid_cyc_no_done", FE_W'(done), '0);
        chk("valid_cyc_busy", FE_W'(busy), FE_W'(1));
        wait_done(50, d);
        chk("valid_cyc_done", FE_W'(d), FE_W'(4'b0010));
        chk("valid_cyc_res", res, FE_W'(35));
        @(negedge clk);

        // reset while busy, then req[1] wins over req[3] (ptr back to 0)
        req = 4'b0100;
        exp_q.push_back(2'd2);
        wait_gnt(20, g);
        chk("abort_gnt", FE_W'(g), FE_W'(4'b0100));
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("abort_busy", FE_W'(busy), '0);
        chk("abort_mul_a", mul_a, '0);
        chk("abort_res", res, '0);
        req = 4'b1010;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd3);
        wait_gnt(20, g);
        chk("post_abort_gnt", FE_W'(g), FE_W'(4'b0010));
        drain(200);
        repeat (3) @(negedge clk);

        chk("exp_q_empty", FE_W'(exp_q.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fe_mul_arb.md
# fe_mul_arb

Round-robin arbiter that shares one `fe_mulx` field multiplier between up to `NREQ` requesters (e.g. `ge_add`, `ge_dbl`, scalar-mult control). Sits between the group-operation blocks and a single top-level `fe_mulx` instance. Runs one multiply at a time:

- grants a requester and latches its operands;
- drives the multiplier's valid/done handshake;
- returns the result with a per-requester done pulse.

## Interface
Parameters:
- `NREQ`, 4 — number of requesters, 2..8.
- `FE_W`, 320 — field-element width (10 limbs × 32 b).

Ports:
- `clk`  in  1 — clock, rising edge.
- `rst`  in  1 — asynchronous, active-low reset.
- `req`  in  NREQ — level request per requester.
- `op_a_flat`  in  NREQ*FE_W — operand A of requester i at bits [i*FE_W +: FE_W].
- `op_b_flat`  in  NREQ*FE_W — operand B, same packing.
- `gnt`  out  NREQ — one-hot, one-cycle pulse; operands of the granted requester have been captured.
- `done`  out  NREQ — one-hot, one-cycle pulse; `res` is valid for requester i.
- `res`  out  FE_W — last product; holds until the next completion.
- `busy`  out  1 — high from grant until `done`.
- `mul_a`, `mul_b`  out  FE_W — multiplier operands; stable while `busy`.
- `mul_valid`  out  1 — one-cycle start pulse to `fe_mulx`.
- `mul_res`  in  FE_W — multiplier product.
- `mul_done`  in  1 — multiplier completion pulse.

## Operation
- Reset values:
  - `gnt`, `done`, `busy`, `mul_valid` = 0.
  - `res`, `mul_a`, `mul_b` = 0.
  - round-robin pointer `ptr` = 0; state = IDLE.
- **IDLE**
  - If `req` ≠ 0, the winner is the first set bit scanning `ptr`, `ptr+1`, … mod NREQ.
  - On that edge: latch the winner's operands into `mul_a`/`mul_b`, record `owner`, set `gnt[owner]`, `mul_valid`, `busy`, and `ptr <= owner+1` (mod NREQ).
  - Go to WAIT.
  - If `req` = 0, stay in IDLE.
- **WAIT**
  - `gnt` and `mul_valid` clear after one cycle.
  - `mul_done` is ignored in the cycle `mul_valid` is high.
  - On a qualifying `mul_done`: `res <= mul_res`, pulse `done[owner]`, clear `busy`, go to IDLE.
- `req` is sampled only in IDLE.
  - Requester i drops `req[i]` no later than the cycle it sees `done[i]`.
  - A `req` still high in IDLE is a new request.
- Operands are sampled once at grant. Requesters may change `op_*` after `gnt`.
- `mul_done` while in IDLE is ignored (no `done` pulse, `res` unchanged).
- Reset mid-operation clears everything immediately and discards the in-flight product. The shared `fe_mulx` uses the same `rst`.
- No arithmetic on data: operands and product pass through unmodified.

## Timing
- Edge t: IDLE samples `req`. Cycle t+1: `gnt` = 1, `mul_valid` = 1, `busy` = 1.
- Edge t+k where `fe_mulx` raises `mul_done` in cycle t+k (k ≥ 2): cycle t+k+1 has `done` = 1, `res` valid, `busy` = 0.
- Earliest next grant: same edge as `done` is issued plus one, i.e. cycle t+k+2.
- Arbitration overhead: 2 cycles per multiply beyond the multiplier latency.
- Under continuous contention, service is strictly round-robin: a requester waits at most NREQ−1 multiplies.

## Structure
- Shared package/include (`fe_common` family):
  - `FE_W`;
  - the state encoding `ARB_IDLE` = 0, `ARB_WAIT` = 1;
  - the `fe_mulx` handshake convention.
- One natural sub-module: `rr_pick`.
  - Combinational; inputs `req` and `ptr`.
  - Outputs a one-hot winner and its index.
  - Reusable for other shared resources (e.g. an inverter).
- Operand mux: indexed part-select on the flattened buses; no per-requester registers.

## Test plan
- **Reset:** hold `rst` = 0 with `req` = 4'b1111 → all outputs 0. Release `rst` → first `gnt` = 4'b0001.
- **Single request:** `req[2]` with `op_a` = 2, `op_b` = 3 (limb 0, real `fe_mulx`) → `gnt` = 4'b0100 one cycle; later `done` = 4'b0100, `res` limb0 = 6, other limbs 0; `busy` deasserts with `done`.
- **Contention:** `req` = 4'b1111 held, each requester dropping after its `done` → grant order 0, 1, 2, 3. Re-assert all → order resumes at 0 (`ptr` wrapped).
- **Fairness:** `req[0]` held continuously and `req[3]` raised → grants alternate 0, 3, 0, 3.
- **Spurious done:** `mul_done` pulse in IDLE → no `done`, `res` unchanged. `mul_done` in the `mul_valid` cycle → ignored, completion taken from the next pulse.
- **Reset mid-operation:** assert `rst` while `busy` → outputs 0 asynchronously, no `done` for the aborted owner. After release, a pending `req[1]` is granted first (`ptr` = 0, `req[0]` = 0).
